dffram_arbiter: RTL and testbench

DFFRAM_ARBITER -- requirements
Module: dffram_arbiter

---
 rtl/dffram_arb_pkg.sv | 25 ++
 rtl/dffram_arbiter_rr_arb2.sv | 20 ++
 rtl/dffram_arbiter.sv | 143 ++++++++++++++
 tb/tb_dffram_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dffram_arb_pkg.sv
// Shared types and constants for the two-requester DFFRAM arbiter.
package dffram_arb_pkg;

  localparam int ADDR_W        = 8;
  localparam int DEPTH_DEFAULT = 256;
  localparam int WSIZE_DEFAULT = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  // One registered response slot: who gets the strobe and whether ram_do is meaningful.
  typedef struct packed {
    logic [1:0] valid;
    logic       read;
  } rsp_t;

  function automatic req_id_t grant_id(input logic [1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/dffram_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the one not granted last.
module rr_arb2
  import dffram_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  req_id_t    last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last == 1'b1) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Two-requester front end for a single-port DFFRAM; define DFFRAM_ARB_INIT_EN to zero-fill the RAM
// after reset before any request is accepted.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int WSIZE = WSIZE_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [WSIZE-1:0]     r0_we,
  input  logic [ADDR_W-1:0]    r0_addr,
  input  logic [WSIZE*8-1:0]   r0_wdata,
  output logic                 r0_rsp_valid,
  output logic [WSIZE*8-1:0]   r0_rdata,

  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [WSIZE-1:0]     r1_we,
  input  logic [ADDR_W-1:0]    r1_addr,
  input  logic [WSIZE*8-1:0]   r1_wdata,
  output logic                 r1_rsp_valid,
  output logic [WSIZE*8-1:0]   r1_rdata,

  output logic                 ram_en,
  output logic [WSIZE-1:0]     ram_we,
  output logic [ADDR_W-1:0]    ram_a,
  output logic [WSIZE*8-1:0]   ram_di,
  input  logic [WSIZE*8-1:0]   ram_do,

  output logic                 init_done
);

  arb_state_t state;
  req_id_t    last;
  rsp_t       rsp;
  logic [1:0] valid;
  logic [1:0] grant;
  logic [1:0] xfer;

  // An 8-bit address cannot reach beyond 256 words; an out-of-range DEPTH yields no logic here.
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_out_of_range
  end

`ifdef DFFRAM_ARB_INIT_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] init_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_addr <= '0;
    end else if (state == INIT) begin
      init_addr <= init_addr + 1'b1;
    end
  end
`endif

  assign valid = {r1_valid, r0_valid};

  rr_arb2 u_rr_arb2 (
    .valid (valid),
    .last  (last),
    .grant (grant)
  );

  assign xfer     = (state == RUN) ? grant : 2'b00;
  assign r0_ready = xfer[0];
  assign r1_ready = xfer[1];

  // The init sweep is gated by rst_n so the RAM port stays quiet while reset is held.
  always_comb begin
    ram_en = 1'b0;
    ram_we = '0;
    ram_a  = '0;
    ram_di = '0;
    if (xfer[0]) begin
      ram_en = 1'b1;
      ram_we = r0_we;
      ram_a  = r0_addr;
      ram_di = r0_wdata;
    end else if (xfer[1]) begin
      ram_en = 1'b1;
      ram_we = r1_we;
      ram_a  = r1_addr;
      ram_di = r1_wdata;
    end
`ifdef DFFRAM_ARB_INIT_EN
    else if (state == INIT && rst_n) begin
      ram_en = 1'b1;
      ram_we = '1;
      ram_a  = init_addr;
      ram_di = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      last      <= 1'b1;
      rsp       <= '0;
      init_done <= 1'b0;
    end else begin
      rsp.valid <= xfer;
      rsp.read  <= (|xfer) && (ram_we == '0);
      if (|xfer) begin
        last <= grant_id(xfer);
      end
      unique case (state)
        INIT: begin
`ifdef DFFRAM_ARB_INIT_EN
          if (init_addr == LAST_ADDR) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
`else
          state     <= RUN;
          init_done <= 1'b1;
`endif
        end
        RUN: begin
          state     <= RUN;
          init_done <= 1'b1;
        end
        default: begin
          state     <= INIT;
          init_done <= 1'b0;
        end
      endcase
    end
  end

  // Write responses return zero; read data is passed straight through from the RAM output.
  assign r0_rsp_valid = rsp.valid[0];
  assign r1_rsp_valid = rsp.valid[1];
  assign r0_rdata     = (rsp.valid[0] && rsp.read) ? ram_do : '0;
  assign r1_rdata     = (rsp.valid[1] && rsp.read) ? ram_do : '0;

endmodule

// File: tb/tb_dffram_arbiter.sv
// Directed bench for dffram_arbiter with a behavioural DFFRAM model; honours DFFRAM_ARB_INIT_EN.
module tb_dffram_arbiter;

  localparam int WSIZE = 2;
  localparam int DW    = WSIZE * 8;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            r0_valid, r1_valid;
  logic            r0_ready, r1_ready;
  logic [WSIZE-1:0] r0_we, r1_we;
  logic [7:0]      r0_addr, r1_addr;
  logic [DW-1:0]   r0_wdata, r1_wdata;
  logic            r0_rsp_valid, r1_rsp_valid;
  logic [DW-1:0]   r0_rdata, r1_rdata;
  logic            ram_en;
  logic [WSIZE-1:0] ram_we;
  logic [7:0]      ram_a;
  logic [DW-1:0]   ram_di;
  logic [DW-1:0]   ram_do;
  logic            init_done;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  dffram_arbiter #(.WSIZE(WSIZE), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_valid     (r0_valid),
    .r0_ready     (r0_ready),
    .r0_we        (r0_we),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rdata     (r0_rdata),
    .r1_valid     (r1_valid),
    .r1_ready     (r1_ready),
    .r1_we        (r1_we),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rdata     (r1_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_a        (ram_a),
    .ram_di       (ram_di),
    .ram_do       (ram_do),
    .init_done    (init_done)
  );

  // Single-port DFFRAM: byte-masked write, read data appears the cycle after the read edge.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < WSIZE; b++) begin
        if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
      end
      if (ram_we == '0) ram_do <= mem[ram_a];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic [WSIZE-1:0] we0,
                               input logic [7:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [WSIZE-1:0] we1,
                               input logic [7:0] a1, input logic [DW-1:0] d1);
    r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`ifdef DFFRAM_ARB_INIT_EN
    checkOutput("init_first_en", ram_en, 1);
    checkOutput("init_first_we", ram_we, 2'b11);
    checkOutput("init_first_a", ram_a, 0);
    for (int i = 1; i < DEPTH; i++) @(negedge clk);
    #1;
    checkOutput("init_done_early", init_done, 0);
    checkOutput("init_last_a", ram_a, DEPTH - 1);
    checkOutput("init_ready_held", {r1_ready, r0_ready}, 0);
`endif
    @(negedge clk);
    #1;
    checkOutput("init_done_rise", init_done, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    applyStimulus(1, 2'b11, 8'h10, 16'hAAAA, 1, 2'b00, 8'h11, 16'h0000);
    #1;
    checkOutput("rst_r0_ready", r0_ready, 0);
    checkOutput("rst_r1_ready", r1_ready, 0);
    checkOutput("rst_ram_en", ram_en, 0);
    checkOutput("rst_ram_we", ram_we, 0);
    checkOutput("rst_ram_a", ram_a, 0);
    checkOutput("rst_ram_di", ram_di, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_rsp", {r1_rsp_valid, r0_rsp_valid}, 0);
    checkOutput("rst_rdata", {r1_rdata, r0_rdata}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    releaseReset();

    // Contention: r0 wins the first tie after reset, then writes set up 0x01/0x02.
    @(negedge clk); applyStimulus(1, 2'b11, 8'h01, 16'h1111, 1, 2'b11, 8'h02, 16'h2222); #1;
    checkOutput("c1_ready", {r1_ready, r0_ready}, 2'b01);
    checkOutput("c1_ram_a", ram_a, 8'h01);
    checkOutput("c1_ram_di", ram_di, 16'h1111);
    checkOutput("c1_ram_we", ram_we, 2'b11);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b11, 8'h02, 16'h2222); #1;
    checkOutput("c2_ready", {r1_ready, r0_ready}, 2'b10);
    checkOutput("c2_ram_a", ram_a, 8'h02);
    checkOutput("c2_r0_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b01);
    checkOutput("c2_r0_rdata", r0_rdata, 0);
    @(negedge clk); applyStimulus(1, 0, 8'h01, 0, 1, 0, 8'h02, 0); #1;
    checkOutput("c3_ready", {r1_ready, r0_ready}, 2'b01);
    checkOutput("c3_r1_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b10);
    checkOutput("c3_r1_rdata", r1_rdata, 0);
    @(negedge clk); #1;
    checkOutput("c4_ready", {r1_ready, r0_ready}, 2'b10);
    checkOutput("c4_r0_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b01);
    checkOutput("c4_r0_rdata", r0_rdata, 16'h1111);
    @(negedge clk); #1;
    checkOutput("c5_ready", {r1_ready, r0_ready}, 2'b01);
    checkOutput("c5_r1_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b10);
    checkOutput("c5_r1_rdata", r1_rdata, 16'h2222);
    @(negedge clk); #1;
    checkOutput("c6_ready", {r1_ready, r0_ready}, 2'b10);
    checkOutput("c6_r0_rdata", r0_rdata, 16'h1111);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("c7_idle_en", ram_en, 0);
    checkOutput("c7_idle_we", ram_we, 0);
    checkOutput("c7_r1_rsp", {r1_rsp_valid, r0_rsp_valid}, 2'b10);
    checkOutput("c7_r1_rdata", r1_rdata, 16'h2222);

    // Single requester: write then read-after-write on the next cycle.
    @(negedge clk); applyStimulus(1, 2'b11, 8'h10, 16'hBEEF, 0, 0, 0, 0); #1;
    checkOutput("s1_ready", {r1_ready, r0_ready}, 2'b01);
    checkOutput("s1_ram_en", ram_en, 1);
    checkOutput("s1_ram_a", ram_a, 8'h10);
    checkOutput("s1_ram_di", ram_di, 16'hBEEF);
    checkOutput("s1_no_rsp", {r1_rsp_valid, r0_rsp_valid}, 0);
    @(negedge clk); applyStimulus(1, 0, 8'h10, 0, 0, 0, 0, 0); #1;
    checkOutput("s2_ready", r0_ready, 1);
    checkOutput("s2_ram_we", ram_we, 0);
    checkOutput("s2_rsp", r0_rsp_valid, 1);
    checkOutput("s2_wr_rdata", r0_rdata, 0);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("s3_rsp", r0_rsp_valid, 1);
    checkOutput("s3_rdata", r0_rdata, 16'hBEEF);
    @(negedge clk); #1;
    checkOutput("s4_rsp_gone", {r1_rsp_valid, r0_rsp_valid}, 0);

    // Byte enables through r1: only the low byte of the second write lands.
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b11, 8'h20, 16'h1234); #1;
    checkOutput("b1_ready", {r1_ready, r0_ready}, 2'b10);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b01, 8'h20, 16'hAB55); #1;
    checkOutput("b2_ram_we", ram_we, 2'b01);
    checkOutput("b2_ram_di", ram_di, 16'hAB55);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b00, 8'h20, 0); #1;
    checkOutput("b3_wr_rdata", r1_rdata, 0);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("b4_rsp", r1_rsp_valid, 1);
    checkOutput("b4_rdata", r1_rdata, 16'h1255);

    // Full sweep: r0 writes data=addr everywhere, r1 reads it all back with no bubbles.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); applyStimulus(1, 2'b11, 8'(i), 16'(i), 0, 0, 0, 0); #1;
      checkOutput("sweep_wr_ready", r0_ready, 1);
    end
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b00, 8'(j), 0); #1;
      checkOutput("sweep_rd_ready", r1_ready, 1);
      if (j > 0) begin
        checkOutput("sweep_rd_rsp", r1_rsp_valid, 1);
        checkOutput("sweep_rd_data", r1_rdata, 32'(j - 1));
      end
    end
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("sweep_last_data", r1_rdata, 16'h00FF);

    // Reset right after an r1 read transfer drops its response.
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b00, 8'h33, 0); #1;
    checkOutput("mid_r1_ready", r1_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    applyStimulus(1, 2'b00, 8'h7F, 0, 1, 2'b00, 8'h80, 0);
    #1;
    checkOutput("mid_rsp", {r1_rsp_valid, r0_rsp_valid}, 0);
    checkOutput("mid_rdata", {r1_rdata, r0_rdata}, 0);
    checkOutput("mid_ready", {r1_ready, r0_ready}, 0);
    checkOutput("mid_ram_en", ram_en, 0);
    checkOutput("mid_ram_a", ram_a, 0);
    checkOutput("mid_init_done", init_done, 0);
    @(negedge clk); #1;
    checkOutput("mid_rsp_held", {r1_rsp_valid, r0_rsp_valid}, 0);
    releaseReset();

    // Requests held across reset are served afterwards, r0 first.
    checkOutput("post_r0_wins", {r1_ready, r0_ready}, 2'b01);
    @(negedge clk); applyStimulus(0, 0, 0, 0, 1, 2'b00, 8'h80, 0); #1;
    checkOutput("post_r1_ready", {r1_ready, r0_ready}, 2'b10);
    checkOutput("post_r0_rsp", r0_rsp_valid, 1);
`ifdef DFFRAM_ARB_INIT_EN
    checkOutput("post_r0_rdata", r0_rdata, 16'h0000);
`else
    checkOutput("post_r0_rdata", r0_rdata, 16'h007F);
`endif
    @(negedge clk); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0); #1;
    checkOutput("post_r1_rsp", r1_rsp_valid, 1);
`ifdef DFFRAM_ARB_INIT_EN
    checkOutput("post_r1_rdata", r1_rdata, 16'h0000);
`else
    checkOutput("post_r1_rdata", r1_rdata, 16'h0080);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
